uart_tx_streamer: RTL and testbench
===================================

// Module: uart_tx_streamer
// PURPOSE
// - Memory-to-UART transmit engine; the send-side counterpart of the rx-to-memory path.
// - On a start command it reads a byte string from data memory and feeds it to one uart transmitter.
// - Stops at a programmed length or at the terminator byte.
// - Sits in the MEM-stage I/O region beside the arbiter and one uart instance; shares dataMem via a req/grant port.
// PARAMETERS
// - ADDR_W   10     data memory word-address width (= `DATA_MEM_ADDR_SIZE)
// - LEN_W    8      width of length and byte counter; max string = 2^LEN_W-1 bytes
// - MEM_LAT  1      cycles from granted address to valid memData (1..3)
// - TERM     8'h0C  terminator byte; checked only when TERM_EN=1
// - TERM_EN  1      1: stop on TERM; 0: length only
// PORTS
// - clk        in   1       system clock (divided pipeline clock)
// - rst        in   1       synchronous, active-high reset
// - start      in   1       one-cycle command pulse from CPU store decode
// - startAddr  in   ADDR_W  word address of first byte
// - length     in   LEN_W   max bytes to send
// - memReq     out  1       request data memory read port
// - memGrant   in   1       arbiter grant; address is taken in a cycle with memReq&memGrant
// - memAddr    out  ADDR_W  read address; valid while memReq=1
// - memData    in   32      read data; byte = memData[7:0]
// - txData     out  8       byte to uart
// - txEnable   out  1       level request to uart
// - txBusy     in   1       uart tx_busy
// - busy       out  1       1 from accepted start until done
// - done       out  1       one-cycle pulse at end of stream
// - byteCount  out  LEN_W   bytes sent in current/last stream
// BEHAVIOUR
// - Reset: all outputs 0; state IDLE; counters 0. rst beats every other input, including start.
// - rst mid-stream: txEnable and memReq drop in the next cycle; no done pulse.
// - Nothing is queued; the uart finishes any byte already shifting.
// - IDLE: on start, latch startAddr/length, clear byteCount, set busy.
//   - length==0: go to DONE with no memory access.
//   - otherwise: go to REQ.
//   - start while busy=1 is ignored.
// - REQ: memReq=1, memAddr=current address. Hold both until memGrant=1, then go to WAIT (MEM_LAT-cycle counter).
// - WAIT: on the last count, latch memData[7:0] into txData and go to CHECK.
// - CHECK:
//   - TERM_EN && byte==TERM: go to DONE; terminator is not sent.
//   - otherwise: go to SEND.
// - SEND: txEnable=1 with txData stable. Hold until txBusy=1, then drop txEnable and go to DRAIN.
//   - txEnable is never high for less than 1 cycle.
// - DRAIN: wait for txBusy=0.
//   - Then byteCount+=1 and address+=1; address wraps 2^ADDR_W-1 -> 0.
//   - byteCount==length: go to DONE.
//   - otherwise: go to REQ.
// - DONE: done=1 for exactly 1 cycle, busy=0, then IDLE. byteCount holds until the next accepted start.
// - Latency per byte: >= 1 (REQ) + MEM_LAT + 1 (CHECK) + uart frame time.
//   First memReq rises the cycle after start.
// - memGrant low in any state other than REQ is ignored.
// - txBusy already high on entering SEND: handshake completes in 1 cycle (accepted behaviour).
// STRUCTURE
// - parameters.v gets:
//   - state encodings `TXS_IDLE/REQ/WAIT/CHECK/SEND/DRAIN/DONE (3 bits)
//   - `TX_TERM 8'h0C (replaces the literal 8'h0c in the rx path)
//   - `DATA_MEM_ADDR_SIZE, reused for ADDR_W
// - Single module; one FSM plus address, byte and latency counters; no sub-module.
// - Top-level hookup:
//   - arbiter gains a third requester for dataMem address/rden.
//   - uart txEnable/txData muxed between CPU store path and streamer, selected by busy.
// TESTING
// - Bench uart model raises txBusy 2 cycles after txEnable and holds it 10 cycles.
// - Scenario 1: start, startAddr=5, length=3, mem[5..7]=0x41,0x42,0x43
//   -> txData 0x41,0x42,0x43 in order; byteCount=3; one done pulse; busy low after.
// - Scenario 2: length=0 -> done the cycle after IDLE->DONE; memReq and txEnable never assert.
// - Scenario 3: TERM_EN=1, length=10, mem=0x48,0x0C,0x49 -> only 0x48 sent; byteCount=1; done.
// - Scenario 4: startAddr=2^ADDR_W-1, length=2 -> reads 1023 then 0.
//   memGrant held low 5 cycles on the first REQ -> memReq and memAddr stable throughout.
// - Scenario 5: rst pulsed while in SEND -> next cycle txEnable=0, memReq=0, busy=0, byteCount=0, no done.
//   A new start then runs normally.
// - Scenario 6: second start pulse mid-stream -> ignored.
//   Same cycle start+rst -> stays IDLE.

Source files
------------

// File: rtl/uart_tx_streamer_pkg.sv
// Shared definitions for the memory-to-UART transmit streamer.
//   DATA_MEM_ADDR_SIZE : data memory word-address width
//   TX_TERM            : string terminator byte
//   txs_state_e        : streamer FSM states
package uart_tx_streamer_pkg;

  localparam int unsigned DATA_MEM_ADDR_SIZE = 10;
  localparam logic [7:0]  TX_TERM            = 8'h0C;

  typedef enum logic [2:0] {
    TXS_IDLE  = 3'd0,
    TXS_REQ   = 3'd1,
    TXS_WAIT  = 3'd2,
    TXS_CHECK = 3'd3,
    TXS_SEND  = 3'd4,
    TXS_DRAIN = 3'd5,
    TXS_DONE  = 3'd6
  } txs_state_e;

endpackage

// File: rtl/uart_tx_streamer.sv
// Memory-to-UART transmit engine. On a start pulse it reads a byte string
// (one byte per data-memory word, bits [7:0]) through a req/grant port and
// hands each byte to a UART transmitter, stopping at the programmed length
// or at the terminator byte.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   start           : one-cycle command; startAddr/length latched with it
//   memReq/memGrant : data memory request, address taken when both high
//   memAddr/memData : read address / read data (MEM_LAT cycles after grant)
//   txData/txEnable : byte and level request to the UART
//   txBusy          : UART busy flag
//   busy/done       : stream in progress / one-cycle end-of-stream pulse
//   byteCount       : bytes sent in the current or last stream
module uart_tx_streamer
  import uart_tx_streamer_pkg::*;
#(
  parameter int unsigned ADDR_W  = DATA_MEM_ADDR_SIZE,
  parameter int unsigned LEN_W   = 8,
  parameter int unsigned MEM_LAT = 1,
  parameter logic [7:0]  TERM    = TX_TERM,
  parameter bit          TERM_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] startAddr,
  input  logic [LEN_W-1:0]  length,
  output logic              memReq,
  input  logic              memGrant,
  output logic [ADDR_W-1:0] memAddr,
  input  logic [31:0]       memData,
  output logic [7:0]        txData,
  output logic              txEnable,
  input  logic              txBusy,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  byteCount
);

  txs_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        lat_q, lat_d;
  logic              mem_req_q, mem_req_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_en_q, tx_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [LEN_W-1:0]  cnt_inc;

  // Only the low byte of each memory word carries string data.
  logic mem_hi_unused;
  assign mem_hi_unused = ^memData[31:8];

  assign cnt_inc = cnt_q + 1'b1;

  // Outputs are registered and updated together with the state they belong
  // to, so each one is already valid in the first cycle of its state.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    lat_d     = lat_q;
    mem_req_d = mem_req_q;
    tx_data_d = tx_data_q;
    tx_en_d   = tx_en_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    unique case (state_q)
      TXS_IDLE: begin
        if (start) begin
          addr_d = startAddr;
          len_d  = length;
          cnt_d  = '0;
          if (length == '0) begin
            state_d = TXS_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d   = TXS_REQ;
            mem_req_d = 1'b1;
            busy_d    = 1'b1;
          end
        end
      end
      TXS_REQ: begin
        if (memGrant) begin
          mem_req_d = 1'b0;
          lat_d     = 2'(MEM_LAT - 1);
          state_d   = TXS_WAIT;
        end
      end
      TXS_WAIT: begin
        if (lat_q == '0) begin
          tx_data_d = memData[7:0];
          state_d   = TXS_CHECK;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      TXS_CHECK: begin
        if (TERM_EN && (tx_data_q == TERM)) begin
          state_d = TXS_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          state_d = TXS_SEND;
          tx_en_d = 1'b1;
        end
      end
      TXS_SEND: begin
        if (txBusy) begin
          tx_en_d = 1'b0;
          state_d = TXS_DRAIN;
        end
      end
      TXS_DRAIN: begin
        if (!txBusy) begin
          cnt_d  = cnt_inc;
          addr_d = addr_q + 1'b1;
          if (cnt_inc == len_q) begin
            state_d = TXS_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d   = TXS_REQ;
            mem_req_d = 1'b1;
          end
        end
      end
      TXS_DONE: state_d = TXS_IDLE;
      default:  state_d = TXS_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= TXS_IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      lat_q     <= '0;
      mem_req_q <= 1'b0;
      tx_data_q <= '0;
      tx_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      lat_q     <= lat_d;
      mem_req_q <= mem_req_d;
      tx_data_q <= tx_data_d;
      tx_en_q   <= tx_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign memReq    = mem_req_q;
  assign memAddr   = addr_q;
  assign txData    = tx_data_q;
  assign txEnable  = tx_en_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign byteCount = cnt_q;

endmodule

// File: tb/tb_uart_tx_streamer.sv
// Bench for uart_tx_streamer: data memory with one-cycle latency and a
// controllable grant, a UART model that raises txBusy two cycles after
// txEnable and holds it ten cycles, a table of stream vectors, and
// hand-written reset / restart sequences.
module tb_uart_tx_streamer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  startAddr = '0;
  logic [7:0]  length = '0;
  logic        memReq;
  logic        memGrant = 1'b1;
  logic [9:0]  memAddr;
  logic [31:0] memData = '0;
  logic [7:0]  txData;
  logic        txEnable;
  logic        txBusy = 1'b0;
  logic        busy;
  logic        done;
  logic [7:0]  byteCount;

  uart_tx_streamer #(.ADDR_W(10), .LEN_W(8), .MEM_LAT(1), .TERM(8'h0C), .TERM_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .startAddr(startAddr), .length(length),
    .memReq(memReq), .memGrant(memGrant), .memAddr(memAddr), .memData(memData),
    .txData(txData), .txEnable(txEnable), .txBusy(txBusy),
    .busy(busy), .done(done), .byteCount(byteCount)
  );

  always #5 clk = ~clk;

  int acount = 0;
  int fcount = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    acount++;
    if (act !== exp) begin
      fcount++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- models and monitors ----------------
  logic [31:0] mem [0:1023];
  logic [7:0]  sent [$];
  logic [9:0]  reads [$];
  int          done_cnt, req_seen, en_seen, stable_err, gnt_block;
  logic        pend_v = 1'b0, prev_req = 1'b0, prev_gnt = 1'b0;
  logic [9:0]  pend_a, prev_addr;
  int          ust = 0, bcnt = 0;

  always @(negedge clk) begin
    if (prev_req && !prev_gnt && memReq && (memAddr !== prev_addr)) stable_err++;
    if (memReq)   req_seen++;
    if (txEnable) en_seen++;
    if (done)     done_cnt++;
    memData = pend_v ? mem[pend_a] : 32'hDEAD_BEEF;
    if (gnt_block > 0) begin
      memGrant = 1'b0;
      if (memReq) gnt_block--;
    end else begin
      memGrant = 1'b1;
    end
    pend_v = memReq && memGrant;
    pend_a = memAddr;
    if (pend_v) reads.push_back(memAddr);
    prev_req  = memReq;
    prev_gnt  = memGrant;
    prev_addr = memAddr;
    case (ust)
      0: if (txEnable) begin sent.push_back(txData); ust = 1; end
      1: begin txBusy = 1'b1; bcnt = 10; ust = 2; end
      default: begin
        bcnt--;
        if (bcnt == 0) begin txBusy = 1'b0; ust = 0; end
      end
    endcase
  end

  // ---------------- vector table ----------------
  typedef struct packed {
    logic [9:0]      addr;
    logic [7:0]      len;
    logic [3:0][7:0] m;
    logic [31:0]     gnt;
    logic [31:0]     exp_n;
    logic [2:0][7:0] e;
    logic [31:0]     exp_reads;
    logic [7:0]      exp_cnt;
  } vec_t;

  function automatic vec_t mkv(input logic [9:0] a, input logic [7:0] l,
                               input logic [7:0] m0, m1, m2, m3, input int g,
                               input int n, input logic [7:0] e0, e1, e2,
                               input int r, input logic [7:0] c);
    vec_t v;
    v.addr = a; v.len = l; v.m = {m3, m2, m1, m0}; v.gnt = g; v.exp_n = n;
    v.e = {e2, e1, e0}; v.exp_reads = r; v.exp_cnt = c;
    return v;
  endfunction

  vec_t vecs [6];

  task automatic wait_uart_idle();
    for (int c = 0; c < 40 && ust != 0; c++) @(negedge clk);
    check("uart_idle_before_start", (ust == 0), 1);
  endtask

  task automatic start_vec(input vec_t v);
    logic [9:0] a;
    wait_uart_idle();
    for (int unsigned i = 0; i < 4; i++) begin
      a = v.addr + 10'(i);
      mem[a] = 32'hC0FF_EE00 | {24'h0, v.m[i]};
    end
    @(negedge clk);
    #1;
    sent.delete(); reads.delete();
    done_cnt = 0; req_seen = 0; en_seen = 0; stable_err = 0;
    gnt_block = v.gnt;
    start = 1'b1; startAddr = v.addr; length = v.len;
    @(negedge clk);
    start = 1'b0; startAddr = 10'h155; length = 8'hAA;
    check("first_cycle_memReq", memReq, (v.len != 0));
    check("first_cycle_done", done, (v.len == 0));
  endtask

  task automatic finish_vec(input vec_t v, input string tag);
    logic [9:0] ea;
    int c;
    for (c = 0; c < 3000; c++) begin
      if (done_cnt > 0) break;
      @(negedge clk);
      #1;
    end
    check({tag, "_done_timeout"}, (c < 3000), 1);
    repeat (4) @(negedge clk);
    #1;
    check({tag, "_done_pulses"}, done_cnt, 1);
    check({tag, "_busy_after"}, busy, 0);
    check({tag, "_byteCount"}, byteCount, v.exp_cnt);
    check({tag, "_bytes_sent"}, sent.size(), v.exp_n);
    for (int unsigned i = 0; i < v.exp_n; i++)
      check($sformatf("%s_byte%0d", tag, i), (i < sent.size()) ? sent[i] : 8'hXX, v.e[i]);
    check({tag, "_reads"}, reads.size(), v.exp_reads);
    for (int unsigned i = 0; i < v.exp_reads; i++) begin
      ea = v.addr + 10'(i);
      check($sformatf("%s_read%0d", tag, i), (i < reads.size()) ? reads[i] : 10'h3FF ^ ea, ea);
    end
    check({tag, "_addr_stable"}, stable_err, 0);
    if (v.len == 0) begin
      check({tag, "_no_memReq"}, req_seen, 0);
      check({tag, "_no_txEnable"}, en_seen, 0);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h1234_5600 | 32'((i % 96) + 32);
    gnt_block = 0;
    //              addr     len   m0     m1     m2     m3    gnt n  e0     e1     e2    rd cnt
    vecs[0] = mkv(10'd5,    8'd3,  8'h41, 8'h42, 8'h43, 8'h44, 0, 3, 8'h41, 8'h42, 8'h43, 3, 8'd3);
    vecs[1] = mkv(10'd100,  8'd0,  8'h55, 8'h56, 8'h57, 8'h58, 0, 0, 8'h00, 8'h00, 8'h00, 0, 8'd0);
    vecs[2] = mkv(10'd50,   8'd10, 8'h48, 8'h0C, 8'h49, 8'h4A, 0, 1, 8'h48, 8'h00, 8'h00, 2, 8'd1);
    vecs[3] = mkv(10'd1023, 8'd2,  8'h61, 8'h62, 8'h63, 8'h64, 5, 2, 8'h61, 8'h62, 8'h00, 2, 8'd2);
    vecs[4] = mkv(10'd300,  8'd2,  8'h10, 8'h11, 8'h12, 8'h13, 0, 2, 8'h10, 8'h11, 8'h00, 2, 8'd2);
    vecs[5] = mkv(10'd7,    8'd1,  8'h0C, 8'h20, 8'h21, 8'h22, 0, 0, 8'h00, 8'h00, 8'h00, 1, 8'd0);

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_memReq", memReq, 0);
    check("rst_txEnable", txEnable, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_byteCount", byteCount, 0);
    check("rst_txData", txData, 0);
    check("rst_memAddr", memAddr, 0);
    rst = 1'b0;

    for (int k = 0; k < 6; k++) begin
      start_vec(vecs[k]);
      finish_vec(vecs[k], $sformatf("vec%0d", k));
    end

    // Reset while in SEND of the second byte
    begin
      int c;
      start_vec(vecs[0]);
      for (c = 0; c < 2000 && !(byteCount == 8'd1 && txEnable); c++) @(negedge clk);
      check("sc5_reach_send2", (c < 2000), 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("sc5_txEnable", txEnable, 0);
      check("sc5_memReq", memReq, 0);
      check("sc5_busy", busy, 0);
      check("sc5_byteCount", byteCount, 0);
      #1 done_cnt = 0;
      repeat (15) @(negedge clk);
      #1;
      check("sc5_no_done", done_cnt, 0);
      start_vec(vecs[4]);
      finish_vec(vecs[4], "sc5_restart");
    end

    // Second start mid-stream is ignored
    start_vec(vecs[0]);
    repeat (10) @(negedge clk);
    start = 1'b1; startAddr = 10'd300; length = 8'd1;
    @(negedge clk);
    start = 1'b0;
    finish_vec(vecs[0], "sc6_restart_ignored");

    // start and rst in the same cycle: stays idle
    wait_uart_idle();
    @(negedge clk);
    #1 req_seen = 0; done_cnt = 0;
    start = 1'b1; rst = 1'b1; startAddr = 10'd5; length = 8'd3;
    @(negedge clk);
    start = 1'b0; rst = 1'b0;
    check("sc6_rst_start_busy", busy, 0);
    check("sc6_rst_start_memReq", memReq, 0);
    repeat (6) @(negedge clk);
    #1;
    check("sc6_rst_start_no_req", req_seen, 0);
    check("sc6_rst_start_no_done", done_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", acount, fcount);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
